// File: rtl/ram_lab_pkg.sv
// Shared types and defaults for the SRAM lab blocks (reader and writer).
// Holds the controller state encoding and the warm-up length.
package ram_lab_pkg;

  localparam int STARTUP_CYCLES_DEFAULT = 10;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int COUNT_W = 9;

  typedef enum logic [2:0] {
    STARTUP,
    IDLE,
    ISSUE,
    WAIT_DATA,
    PRESENT,
    DONE
  } ramState_e;

  // Wraps naturally from 8'hFF to 8'h00, so 256-word bursts cover every address once.
  function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/ram_reader_if.sv
// Consumer-facing request/stream interface of the SRAM burst reader.
// The reader sits on the slave side; the requesting/consuming block uses master.
interface ram_reader_if;
  import ram_lab_pkg::*;

  logic               start;
  logic [ADDR_W-1:0]  base_addr;
  logic [COUNT_W-1:0] count;
  logic               out_ready;
  logic [DATA_W-1:0]  x;
  logic               out_valid;
  logic               busy;
  logic               fim;
  logic [DATA_W-1:0]  checksum;

  modport master (
    output start, base_addr, count, out_ready,
    input  x, out_valid, busy, fim, checksum
  );

  modport slave (
    input  start, base_addr, count, out_ready,
    output x, out_valid, busy, fim, checksum
  );

endinterface

// File: rtl/ram_reader_spram.sv
// Behavioural model of the 256x8 single-port SRAM macro with registered read data.
// Active-low enable/write/output-enable; Q reads as zero while the output is disabled.
module SPRAM256X8 (
  input  logic       CLK,
  input  logic [7:0] ADR,
  input  logic [7:0] D,
  output logic [7:0] Q,
  input  logic       WEB,
  input  logic       ENB,
  input  logic       OEB,
  input  logic       ramvdd,
  input  logic       ramgnd,
  output logic       RTEST
);

  logic [7:0] mem [0:255];
  logic [7:0] qReg;
  logic       powerGood;

  assign powerGood = ramvdd & ~ramgnd;

  // One access per enabled edge: either a write, or a read into the output register.
  always_ff @(posedge CLK) begin
    if (powerGood && !ENB) begin
      if (!WEB) begin
        mem[ADR] <= D;
      end else begin
        qReg <= mem[ADR];
      end
    end
  end

  assign Q     = OEB ? 8'h00 : qReg;
  assign RTEST = powerGood;

endmodule

// File: rtl/ram_reader.sv
// Burst reader: waits out SRAM warm-up, then streams count words from base_addr
// through a valid/ready output while accumulating a modulo-256 checksum.
module ram_reader
  import ram_lab_pkg::*;
#(
  parameter int STARTUP_CYCLES = STARTUP_CYCLES_DEFAULT
) (
  input logic         clk,
  input logic         reset,
  ram_reader_if.slave bus
);

  ramState_e          state_q, state_d;
  logic [15:0]        startCnt_q, startCnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0]  checksum_q, checksum_d;
  logic [DATA_W-1:0]  x_q, x_d;

  logic               startDone;
  logic               startTaken;
  logic               accept;
  logic               busy;
  logic               outValid;
  logic               fim;
  logic               sramEnb;
  logic               sramOeb;
  logic [DATA_W-1:0]  sramQ;

  assign startDone  = (int'(startCnt_q) + 1) >= STARTUP_CYCLES;
  assign startTaken = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
  assign accept     = (state_q == PRESENT) && bus.out_ready;

  // State and datapath registers; reset abandons any burst and restarts warm-up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= STARTUP;
      startCnt_q  <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      checksum_q  <= '0;
      x_q         <= '0;
    end else begin
      state_q     <= state_d;
      startCnt_q  <= startCnt_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      checksum_q  <= checksum_d;
      x_q         <= x_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STARTUP:   if (startDone) state_d = IDLE;
      IDLE,
      DONE:      if (bus.start) state_d = (bus.count == '0) ? DONE : ISSUE;
      ISSUE:     state_d = WAIT_DATA;
      WAIT_DATA: state_d = PRESENT;
      PRESENT:   if (accept) state_d = (remaining_q == COUNT_W'(1)) ? DONE : ISSUE;
      default:   state_d = STARTUP;
    endcase
  end

  // SRAM read data lands in Q during WAIT_DATA, one edge after the ISSUE access.
  always_comb begin
    startCnt_d  = startCnt_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    checksum_d  = checksum_q;
    x_d         = x_q;
    if ((state_q == STARTUP) && !startDone) begin
      startCnt_d = startCnt_q + 16'd1;
    end
    if (startTaken) begin
      addr_d      = bus.base_addr;
      remaining_d = bus.count;
      checksum_d  = '0;
    end
    if (state_q == WAIT_DATA) begin
      x_d = sramQ;
    end
    if (accept) begin
      checksum_d  = checksum_q + x_q;
      addr_d      = nextAddr(addr_q);
      remaining_d = remaining_q - COUNT_W'(1);
    end
  end

  always_comb begin
    busy     = 1'b1;
    outValid = 1'b0;
    fim      = 1'b0;
    sramEnb  = 1'b1;
    sramOeb  = 1'b1;
    case (state_q)
      IDLE:      busy = 1'b0;
      DONE: begin
        busy = 1'b0;
        fim  = 1'b1;
      end
      ISSUE: begin
        sramEnb = 1'b0;
        sramOeb = 1'b0;
      end
      WAIT_DATA: sramOeb = 1'b0;
      PRESENT:   outValid = 1'b1;
      default:   busy = 1'b1;
    endcase
  end

  // Read-only use of the macro: write strobe parked high, data-in grounded.
  SPRAM256X8 U1 (
    .CLK    (clk),
    .ADR    (addr_q),
    .D      (8'h00),
    .Q      (sramQ),
    .WEB    (1'b1),
    .ENB    (sramEnb),
    .OEB    (sramOeb),
    .ramvdd (1'b1),
    .ramgnd (1'b0),
    .RTEST  ()
  );

  assign bus.x         = x_q;
  assign bus.out_valid = outValid;
  assign bus.busy      = busy;
  assign bus.fim       = fim;
  assign bus.checksum  = checksum_q;

endmodule
